// File: rtl/key_token_pkg.sv
// Shared definitions for the key token queue: token codes, PS/2 set-2
// scancodes of the keys we care about, tracker states and the decode table.
package key_token_pkg;

  // Token values handed to the game/entry FSMs
  localparam logic [3:0] TOK_0     = 4'h0;
  localparam logic [3:0] TOK_1     = 4'h1;
  localparam logic [3:0] TOK_2     = 4'h2;
  localparam logic [3:0] TOK_3     = 4'h3;
  localparam logic [3:0] TOK_4     = 4'h4;
  localparam logic [3:0] TOK_5     = 4'h5;
  localparam logic [3:0] TOK_6     = 4'h6;
  localparam logic [3:0] TOK_7     = 4'h7;
  localparam logic [3:0] TOK_8     = 4'h8;
  localparam logic [3:0] TOK_9     = 4'h9;
  localparam logic [3:0] TOK_SPACE = 4'hA;
  localparam logic [3:0] TOK_ENTER = 4'hB;
  localparam logic [3:0] TOK_BKSP  = 4'hC;
  localparam logic [3:0] TOK_NONE  = 4'hF;

  // Top-row digit scancodes (bit 8 = extended prefix, always 0 here)
  localparam logic [8:0] SC_0 = 9'h045;
  localparam logic [8:0] SC_1 = 9'h016;
  localparam logic [8:0] SC_2 = 9'h01E;
  localparam logic [8:0] SC_3 = 9'h026;
  localparam logic [8:0] SC_4 = 9'h025;
  localparam logic [8:0] SC_5 = 9'h02E;
  localparam logic [8:0] SC_6 = 9'h036;
  localparam logic [8:0] SC_7 = 9'h03D;
  localparam logic [8:0] SC_8 = 9'h03E;
  localparam logic [8:0] SC_9 = 9'h046;

  // Keypad digit scancodes
  localparam logic [8:0] SC_KP0 = 9'h070;
  localparam logic [8:0] SC_KP1 = 9'h069;
  localparam logic [8:0] SC_KP2 = 9'h072;
  localparam logic [8:0] SC_KP3 = 9'h07A;
  localparam logic [8:0] SC_KP4 = 9'h06B;
  localparam logic [8:0] SC_KP5 = 9'h073;
  localparam logic [8:0] SC_KP6 = 9'h074;
  localparam logic [8:0] SC_KP7 = 9'h06C;
  localparam logic [8:0] SC_KP8 = 9'h075;
  localparam logic [8:0] SC_KP9 = 9'h07D;

  // Editing keys (keypad ENTER is extended 15A and intentionally unmapped)
  localparam logic [8:0] SC_SPACE = 9'h029;
  localparam logic [8:0] SC_ENTER = 9'h05A;
  localparam logic [8:0] SC_BKSP  = 9'h066;

  // Held-key tracker states
  typedef enum logic {
    TRK_IDLE = 1'b0,
    TRK_HELD = 1'b1
  } trk_state_e;

  // Scancode to token; TOK_NONE marks a key that must be ignored
  function automatic logic [3:0] sc_to_tok(input logic [8:0] sc);
    logic [3:0] tok;
    tok = TOK_NONE;
    case (sc)
      SC_0, SC_KP0: tok = TOK_0;
      SC_1, SC_KP1: tok = TOK_1;
      SC_2, SC_KP2: tok = TOK_2;
      SC_3, SC_KP3: tok = TOK_3;
      SC_4, SC_KP4: tok = TOK_4;
      SC_5, SC_KP5: tok = TOK_5;
      SC_6, SC_KP6: tok = TOK_6;
      SC_7, SC_KP7: tok = TOK_7;
      SC_8, SC_KP8: tok = TOK_8;
      SC_9, SC_KP9: tok = TOK_9;
      SC_SPACE:     tok = TOK_SPACE;
      SC_ENTER:     tok = TOK_ENTER;
      SC_BKSP:      tok = TOK_BKSP;
      default:      tok = TOK_NONE;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO. Pointers carry one extra wrap bit so that full
// and empty can be told apart without a separate occupancy counter.
// Read data is taken straight from the head slot and forced to zero when
// empty so the consumer never sees stale contents.
module sync_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,     // asynchronous, active-low
  input  logic          clr,     // synchronous flush
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          drop     // push refused because the FIFO is full
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         full;
  logic         pop_en;
  logic         push_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count = wr_q - rd_q;

  // A pop on an empty FIFO is ignored (no bypass); a pop on a full FIFO
  // frees the slot the same-cycle push lands in.
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign drop    = push && full && !pop_en;

  assign rdata = empty ? '0 : mem[rd_q[AW-1:0]];

  // Next pointer values; flush wins over any push or pop
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_en) wr_d = wr_q + PTR_ONE;
      if (pop_en)  rd_d = rd_q + PTR_ONE;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents need no reset because empty masks them
  always_ff @(posedge clk) begin
    if (push_en && !clr) begin
      mem[wr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/key_token_queue.sv
// Turns KeyboardDecoder make/break strobes into one token per new key press
// and queues the tokens for a valid/ready consumer. Only one key is tracked
// at a time: while it is held, other presses and autorepeat makes are
// ignored. A token reaches the FIFO one cycle after the press is seen.
module key_token_queue
  import key_token_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,          // asynchronous, active-low
  input  logic [511:0]  key_down,
  input  logic [8:0]    last_change,
  input  logic          key_valid,
  input  logic          clr,
  input  logic          tok_ready,
  output logic          tok_valid,
  output logic [3:0]    tok_data,
  output logic [AW:0]   count,
  output logic          overflow
);

  trk_state_e  state_q, state_d;
  logic [8:0]  held_code_q, held_code_d;
  logic        push_v_q, push_v_d;
  logic [3:0]  push_tok_q, push_tok_d;
  logic        overflow_q, overflow_d;

  logic [3:0]  dec_tok;
  logic        dec_mapped;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        fifo_drop;

  assign dec_tok    = sc_to_tok(last_change);
  assign dec_mapped = (dec_tok != TOK_NONE);

  assign tok_valid = !fifo_empty;
  assign fifo_pop  = tok_valid && tok_ready;
  assign overflow  = overflow_q;

  // Tracker next state: lock onto a mapped press, wait for its release
  always_comb begin
    state_d     = state_q;
    held_code_d = held_code_q;
    push_v_d    = 1'b0;
    push_tok_d  = push_tok_q;
    if (clr) begin
      state_d     = TRK_IDLE;
      held_code_d = '0;
    end else begin
      case (state_q)
        TRK_IDLE: begin
          if (key_valid && key_down[last_change] && dec_mapped) begin
            state_d     = TRK_HELD;
            held_code_d = last_change;
            push_v_d    = 1'b1;
            push_tok_d  = dec_tok;
          end
        end
        TRK_HELD: begin
          // Any strobe that shows the held key up ends the hold
          if (key_valid && !key_down[held_code_q]) begin
            state_d = TRK_IDLE;
          end
        end
        default: state_d = TRK_IDLE;
      endcase
    end
  end

  // Sticky overflow: set on a dropped push, cleared only by flush or reset
  always_comb begin
    overflow_d = overflow_q;
    if (clr) begin
      overflow_d = 1'b0;
    end else if (fifo_drop) begin
      overflow_d = 1'b1;
    end
  end

  // Tracker, push register and overflow flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= TRK_IDLE;
      held_code_q <= '0;
      push_v_q    <= 1'b0;
      push_tok_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_code_q <= held_code_d;
      push_v_q    <= push_v_d;
      push_tok_q  <= push_tok_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo #(
    .W     (4),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push_v_q),
    .wdata (push_tok_q),
    .pop   (fifo_pop),
    .rdata (tok_data),
    .empty (fifo_empty),
    .count (count),
    .drop  (fifo_drop)
  );

endmodule

// File: tb/tb_key_token_queue.sv
// Bench for key_token_queue: directed sequences with hand-derived
// expectations, one table-driven sequence, then randomized traffic checked
// against a queue-based reference model of the token rules.
module tb_key_token_queue;

  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [511:0]  key_down;
  logic [8:0]    last_change;
  logic          key_valid;
  logic          clr;
  logic          tok_ready;
  logic          tok_valid;
  logic [3:0]    tok_data;
  logic [2:0]    count;
  logic          overflow;

  always #5 clk = ~clk;

  key_token_queue #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .clr         (clr),
    .tok_ready   (tok_ready),
    .tok_valid   (tok_valid),
    .tok_data    (tok_data),
    .count       (count),
    .overflow    (overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Physical key state as the keyboard would report it
  logic [511:0] kd;

  // Reference model state
  int         mq[$];     // tokens waiting for the consumer
  bit         m_ovf;
  bit         m_held;
  logic [8:0] m_hcode;
  bit         m_pend;    // a press seen last cycle whose token enters the queue now
  int         m_ptok;

  typedef struct {
    bit         kv;
    logic [8:0] code;
    bit         mk;
    bit         rdy;
    bit         c;
    bit         e_tv;
    int         e_d;
    int         e_c;
    bit         e_o;
  } vec_t;

  vec_t tbl[14];

  function automatic int tok_of(input logic [8:0] sc);
    int top_row[10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
    int keypad[10]  = '{'h70, 'h69, 'h72, 'h7A, 'h6B, 'h73, 'h74, 'h6C, 'h75, 'h7D};
    for (int i = 0; i < 10; i++) begin
      if (int'(sc) == top_row[i] || int'(sc) == keypad[i]) return i;
    end
    if (sc == 9'h029) return 10;
    if (sc == 9'h05A) return 11;
    if (sc == 9'h066) return 12;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp4(input string nm, input bit tv, input int d, input int c, input bit o);
    chk({nm, " tok_valid"}, 32'(tok_valid), int'(tv));
    chk({nm, " tok_data"}, 32'(tok_data), d);
    chk({nm, " count"}, 32'(count), c);
    chk({nm, " overflow"}, 32'(overflow), int'(o));
  endtask

  function automatic void model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_held  = 1'b0;
    m_hcode = '0;
    m_pend  = 1'b0;
  endfunction

  // Apply the rules for one clock edge given the inputs presented to it
  task automatic model_edge(input bit kv, input logic [8:0] code, input bit rdy, input bit c);
    bit do_pop;
    bit new_pend;
    int t;
    if (c) begin
      model_reset();
      return;
    end
    do_pop = (mq.size() > 0) && rdy;
    if (do_pop) begin
      $display("pop  token %0h at t=%0t", mq[0], $time);
      void'(mq.pop_front());
    end
    if (m_pend) begin
      if (mq.size() < DEPTH) mq.push_back(m_ptok);
      else m_ovf = 1'b1;
    end
    new_pend = 1'b0;
    if (kv) begin
      if (!m_held) begin
        t = tok_of(code);
        if (kd[code] && t >= 0) begin
          m_held   = 1'b1;
          m_hcode  = code;
          new_pend = 1'b1;
          m_ptok   = t;
        end
      end else if (!kd[m_hcode]) begin
        m_held = 1'b0;
      end
    end
    m_pend = new_pend;
  endtask

  // One clock cycle: drive inputs, let the edge happen, compare with the model
  task automatic step(input bit kv, input logic [8:0] code, input bit mk, input bit rdy, input bit c);
    int exp_d;
    if (kv) begin
      kd[code]    = mk;
      last_change = code;
    end
    key_down  = kd;
    key_valid = kv;
    tok_ready = rdy;
    clr       = c;
    model_edge(kv, code, rdy, c);
    @(posedge clk);
    #1;
    exp_d = (mq.size() > 0) ? mq[0] : 0;
    chk("model tok_valid", 32'(tok_valid), int'(mq.size() > 0));
    chk("model tok_data", 32'(tok_data), exp_d);
    chk("model count", 32'(count), mq.size());
    chk("model overflow", 32'(overflow), int'(m_ovf));
  endtask

  task automatic press(input logic [8:0] code, input bit rdy);
    step(1'b1, code, 1'b1, rdy, 1'b0);
  endtask

  task automatic rel(input logic [8:0] code, input bit rdy);
    step(1'b1, code, 1'b0, rdy, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 9'h000, 1'b0, rdy, 1'b0);
  endtask

  task automatic pulse_clr();
    step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset(input string nm);
    @(negedge clk);
    key_valid = 1'b0;
    clr       = 1'b0;
    rst       = 1'b0;
    model_reset();
    #1;
    exp4(nm, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish by t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] pool[11];
    kd          = '0;
    key_down    = '0;
    last_change = '0;
    key_valid   = 1'b0;
    clr         = 1'b0;
    tok_ready   = 1'b0;
    rst         = 1'b0;
    model_reset();
    #2;
    exp4("reset", 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // 1: two presses, consumer always ready
    press(9'h016, 1'b1); exp4("t1 make1", 1'b0, 0, 0, 1'b0);
    idle(1'b1);          exp4("t1 tok1",  1'b1, 1, 1, 1'b0);
    idle(1'b1);          exp4("t1 pop1",  1'b0, 0, 0, 1'b0);
    rel(9'h016, 1'b1);
    press(9'h01E, 1'b1); exp4("t1 make2", 1'b0, 0, 0, 1'b0);
    idle(1'b1);          exp4("t1 tok2",  1'b1, 2, 1, 1'b0);
    idle(1'b1);          exp4("t1 pop2",  1'b0, 0, 0, 1'b0);
    rel(9'h01E, 1'b1);
    $display("t1 done: tokens 1,2 observed");

    // 2: autorepeat of the held key yields a single token
    press(9'h03D, 1'b0);
    for (int i = 0; i < 5; i++) press(9'h03D, 1'b0);
    rel(9'h03D, 1'b0);
    idle(1'b0);          exp4("t2 single", 1'b1, 7, 1, 1'b0);
    idle(1'b1);          exp4("t2 drain",  1'b0, 0, 0, 1'b0);
    $display("t2 done: one token 7");

    // 3: table-driven fill past full with the consumer stalled, then drain
    tbl[0]  = '{1'b1, 9'h045, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[1]  = '{1'b1, 9'h045, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0};
    tbl[2]  = '{1'b1, 9'h016, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0};
    tbl[3]  = '{1'b1, 9'h016, 1'b0, 1'b0, 1'b0, 1'b1, 0, 2, 1'b0};
    tbl[4]  = '{1'b1, 9'h01E, 1'b1, 1'b0, 1'b0, 1'b1, 0, 2, 1'b0};
    tbl[5]  = '{1'b1, 9'h01E, 1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0};
    tbl[6]  = '{1'b1, 9'h026, 1'b1, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0};
    tbl[7]  = '{1'b1, 9'h026, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4, 1'b0};
    tbl[8]  = '{1'b1, 9'h025, 1'b1, 1'b0, 1'b0, 1'b1, 0, 4, 1'b0};
    tbl[9]  = '{1'b1, 9'h025, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4, 1'b1};
    tbl[10] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1, 3, 1'b1};
    tbl[11] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 2, 2, 1'b1};
    tbl[12] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 3, 1, 1'b1};
    tbl[13] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1};
    pulse_clr();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].kv, tbl[i].code, tbl[i].mk, tbl[i].rdy, tbl[i].c);
      exp4($sformatf("t3 row%0d", i), tbl[i].e_tv, tbl[i].e_d, tbl[i].e_c, tbl[i].e_o);
      $display("t3 row %0d: tok_valid=%0b tok_data=%0h count=%0d overflow=%0b",
               i, tok_valid, tok_data, count, overflow);
    end

    // 4: push into a full FIFO on the same cycle as a pop
    pulse_clr();         exp4("t4 clr", 1'b0, 0, 0, 1'b0);
    press(9'h069, 1'b0); rel(9'h069, 1'b0);
    press(9'h072, 1'b0); rel(9'h072, 1'b0);
    press(9'h07A, 1'b0); rel(9'h07A, 1'b0);
    press(9'h06B, 1'b0); rel(9'h06B, 1'b0);
    exp4("t4 full", 1'b1, 1, 4, 1'b0);
    press(9'h073, 1'b0); exp4("t4 pend", 1'b1, 1, 4, 1'b0);
    rel(9'h073, 1'b1);   exp4("t4 swap", 1'b1, 2, 4, 1'b0);
    idle(1'b1);          exp4("t4 d3",   1'b1, 3, 3, 1'b0);
    idle(1'b1);          exp4("t4 d4",   1'b1, 4, 2, 1'b0);
    idle(1'b1);          exp4("t4 d5",   1'b1, 5, 1, 1'b0);
    idle(1'b1);          exp4("t4 end",  1'b0, 0, 0, 1'b0);
    $display("t4 done: tail token 5 accepted while full");

    // 5: other keys ignored during a hold; unmapped key does not lock
    press(9'h029, 1'b0);
    press(9'h016, 1'b0);
    rel(9'h016, 1'b0);
    rel(9'h029, 1'b0);
    idle(1'b0);
    idle(1'b0);          exp4("t5 space", 1'b1, 10, 1, 1'b0);
    idle(1'b1);          exp4("t5 drain", 1'b0, 0, 0, 1'b0);
    press(9'h01C, 1'b0);
    idle(1'b0);
    idle(1'b0);          exp4("t5 unmapped", 1'b0, 0, 0, 1'b0);
    press(9'h016, 1'b0);
    idle(1'b0);          exp4("t5 after unmapped", 1'b1, 1, 1, 1'b0);
    rel(9'h016, 1'b0);
    rel(9'h01C, 1'b0);
    idle(1'b1);          exp4("t5 end", 1'b0, 0, 0, 1'b0);
    $display("t5 done: space only, unmapped ignored");

    // 6: flush with overflow set, press discarded under clr, then reset mid-stream
    press(9'h045, 1'b0); rel(9'h045, 1'b0);
    press(9'h016, 1'b0); rel(9'h016, 1'b0);
    press(9'h01E, 1'b0); rel(9'h01E, 1'b0);
    press(9'h026, 1'b0); rel(9'h026, 1'b0);
    press(9'h025, 1'b0); rel(9'h025, 1'b0);
    idle(1'b1);
    idle(1'b1);          exp4("t6 pre-clr", 1'b1, 2, 2, 1'b1);
    pulse_clr();         exp4("t6 clr",     1'b0, 0, 0, 1'b0);
    press(9'h070, 1'b0);
    idle(1'b0);          exp4("t6 kp0",     1'b1, 0, 1, 1'b0);
    rel(9'h070, 1'b0);
    idle(1'b1);          exp4("t6 drain",   1'b0, 0, 0, 1'b0);
    step(1'b1, 9'h046, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);          exp4("t6 clr+key", 1'b0, 0, 0, 1'b0);
    rel(9'h046, 1'b0);
    press(9'h016, 1'b0); rel(9'h016, 1'b0);
    press(9'h01E, 1'b0); rel(9'h01E, 1'b0);
    press(9'h045, 1'b0);
    idle(1'b0);          exp4("t6 pre-rst", 1'b1, 1, 3, 1'b0);
    do_reset("t6 in reset");
    idle(1'b0);          exp4("t6 post-rst", 1'b0, 0, 0, 1'b0);
    press(9'h045, 1'b0);
    idle(1'b0);          exp4("t6 held refire", 1'b1, 0, 1, 1'b0);
    rel(9'h045, 1'b0);
    idle(1'b1);          exp4("t6 end", 1'b0, 0, 0, 1'b0);
    $display("t6 done: clr and reset recover");

    // Randomized traffic against the reference model
    pool = '{9'h016, 9'h01E, 9'h045, 9'h070, 9'h07D, 9'h029,
             9'h05A, 9'h066, 9'h01C, 9'h01A, 9'h15A};
    for (int i = 0; i < 2000; i++) begin
      int r;
      bit rdy;
      logic [8:0] code;
      r    = $urandom_range(99);
      rdy  = (((i / 200) % 2) == 1) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      code = pool[$urandom_range(10)];
      if (r < 2) begin
        step(1'($urandom_range(1)), code, 1'($urandom_range(1)), rdy, 1'b1);
      end else if (r < 3) begin
        do_reset("rand reset");
      end else if (r < 45) begin
        step(1'b1, code, 1'($urandom_range(1)), rdy, 1'b0);
      end else begin
        idle(rdy);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
